// File: rtl/note_sequencer.sv
// note_sequencer
//   Plays a short melody from an internal constant ROM. Each ROM entry is
//   {note[7:0], dur[3:0]}; the entry lasts dur+1 duration ticks, and one tick
//   is TICK_DIV clock cycles. With GAP_EN=1, every entry is followed by one
//   silent tick.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : single-cycle start request (ignored while busy)
//   stop   : single-cycle abort request, highest priority
//   loop   : level; wrap to entry 0 after the last entry instead of finishing
//   note   : registered note code, 0 = silence, 1..36 = note
//   busy   : high while playing an entry or a gap
//   step   : index of the current ROM entry
//   done   : one-cycle pulse on natural song completion
module note_sequencer #(
    parameter int TICK_DIV = 6_250_000,
    parameter int SONG_LEN = 8,
    parameter int GAP_EN   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic [7:0] note,
    output logic       busy,
    output logic [4:0] step,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [4:0]      LAST_STEP = 5'(SONG_LEN - 1);
    localparam bit              GAP_ON    = (GAP_EN != 0);

    function automatic logic [11:0] rom_entry(input logic [4:0] idx);
        logic [11:0] e;
        case (idx)
            5'd0:    e = {8'd13, 4'd1};
            5'd1:    e = {8'd15, 4'd1};
            5'd2:    e = {8'd17, 4'd1};
            5'd3:    e = {8'd18, 4'd3};
            5'd4:    e = {8'd0,  4'd0};
            5'd5:    e = {8'd20, 4'd1};
            5'd6:    e = {8'd22, 4'd1};
            5'd7:    e = {8'd25, 4'd3};
            default: e = 12'h000;
        endcase
        return e;
    endfunction

    // Entry length in ticks: dur+1, range 1..16.
    function automatic logic [4:0] ticks_of(input logic [11:0] e);
        return {1'b0, e[3:0]} + 5'd1;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic [4:0]       remaining;

    logic        tick;
    logic        last_entry;
    logic [4:0]  next_idx;
    logic [11:0] next_entry;
    logic [11:0] first_entry;
    logic        advance;

    assign tick        = busy && (tick_cnt == CNT_MAX);
    assign last_entry  = (step == LAST_STEP);
    assign next_idx    = last_entry ? 5'd0 : step + 5'd1;
    assign next_entry  = rom_entry(next_idx);
    assign first_entry = rom_entry(5'd0);

    // Move to the following entry on the tick that closes a gap, or the tick
    // that closes the final tick of an entry when no gap is inserted.
    assign advance = tick && ((state == GAP) ||
                              (state == PLAY && remaining <= 5'd1 && !GAP_ON));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            note      <= 8'd0;
            step      <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tick_cnt  <= '0;
            remaining <= 5'd0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            end

            if (stop) begin
                state     <= IDLE;
                note      <= 8'd0;
                step      <= 5'd0;
                busy      <= 1'b0;
                tick_cnt  <= '0;
                remaining <= 5'd0;
            end else if (state == IDLE) begin
                if (start) begin
                    state     <= PLAY;
                    busy      <= 1'b1;
                    step      <= 5'd0;
                    note      <= first_entry[11:4];
                    remaining <= ticks_of(first_entry);
                    tick_cnt  <= '0;
                end
            end else if (advance) begin
                if (last_entry && !loop) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    note      <= 8'd0;
                    step      <= 5'd0;
                    remaining <= 5'd0;
                    done      <= 1'b1;
                end else begin
                    state     <= PLAY;
                    step      <= next_idx;
                    note      <= next_entry[11:4];
                    remaining <= ticks_of(next_entry);
                end
            end else if (state == PLAY && tick) begin
                if (remaining > 5'd1) begin
                    remaining <= remaining - 5'd1;
                end else begin
                    // Entry finished with gaps enabled: one silent tick.
                    state <= GAP;
                    note  <= 8'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with TICK_DIV=4 and the default ROM. Two instances
// share the inputs: one without gaps, one with gaps.
module tb_note_sequencer;

    localparam int TD  = 4;
    localparam int LEN = 8;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, loop;
    logic [7:0] n0, n1;
    logic       b0, b1, d0, d1;
    logic [4:0] s0, s1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    note_sequencer #(.TICK_DIV(TD), .SONG_LEN(LEN), .GAP_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .note(n0), .busy(b0), .step(s0), .done(d0));

    note_sequencer #(.TICK_DIV(TD), .SONG_LEN(LEN), .GAP_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .note(n1), .busy(b1), .step(s1), .done(d1));

    // Reference model: the song as a sequence of timed segments (entries and
    // optional gaps), each lasting a whole number of clock cycles.
    int song_note[LEN] = '{13, 15, 17, 18, 0, 20, 22, 25};
    int song_dur[LEN]  = '{1, 1, 1, 3, 0, 1, 1, 3};

    typedef struct {
        bit play;
        int idx;
        bit gap;
        int left;
        bit done;
    } mdl_t;

    mdl_t m0, m1;

    function automatic int seg_len(int i);
        return (song_dur[i] + 1) * TD;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit g, bit st, bit sp, bit lp);
        mdl_t n = m;
        n.done = 1'b0;
        if (sp) begin
            n.play = 1'b0; n.idx = 0; n.gap = 1'b0; n.left = 0;
        end else if (!m.play) begin
            if (st) begin
                n.play = 1'b1; n.idx = 0; n.gap = 1'b0; n.left = seg_len(0);
            end
        end else begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                if (g && !m.gap) begin
                    n.gap = 1'b1; n.left = TD;
                end else if (m.idx < LEN - 1) begin
                    n.idx = m.idx + 1; n.gap = 1'b0; n.left = seg_len(n.idx);
                end else if (lp) begin
                    n.idx = 0; n.gap = 1'b0; n.left = seg_len(0);
                end else begin
                    n.play = 1'b0; n.idx = 0; n.gap = 1'b0; n.done = 1'b1;
                end
            end
        end
        return n;
    endfunction

    function automatic mdl_t mreset();
        mdl_t n;
        n.play = 1'b0; n.idx = 0; n.gap = 1'b0; n.left = 0; n.done = 1'b0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= mreset();
            m1 <= mreset();
        end else begin
            m0 <= mstep(m0, 1'b0, start, stop, loop);
            m1 <= mstep(m1, 1'b1, start, stop, loop);
        end
    end

    function automatic int exp_note(mdl_t m);
        return (m.play && !m.gap) ? song_note[m.idx] : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_models();
        chk("m0_note", int'(n0), exp_note(m0));
        chk("m0_step", int'(s0), m0.idx);
        chk("m0_busy", int'(b0), int'(m0.play));
        chk("m0_done", int'(d0), int'(m0.done));
        chk("m1_note", int'(n1), exp_note(m1));
        chk("m1_step", int'(s1), m1.idx);
        chk("m1_busy", int'(b1), int'(m1.play));
        chk("m1_done", int'(d1), int'(m1.done));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        check_models();
    endtask

    // Table of {cycle, instance, start input, expected note/step/busy/done}.
    typedef struct {
        int cyc;
        int dut;
        bit st;
        int note;
        int step;
        int busy;
        int done;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int c, int d, bit s, int n, int st, int b, int dn);
        vec_t v;
        v.cyc = c; v.dut = d; v.st = s; v.note = n; v.step = st; v.busy = b; v.done = dn;
        tbl.push_back(v);
    endfunction

    task automatic check_vec(vec_t v);
        string tag;
        tag = $sformatf("tbl_c%0d_d%0d", v.cyc, v.dut);
        if (v.dut == 0) begin
            chk({tag, "_note"}, int'(n0), v.note);
            chk({tag, "_step"}, int'(s0), v.step);
            chk({tag, "_busy"}, int'(b0), v.busy);
            chk({tag, "_done"}, int'(d0), v.done);
        end else begin
            chk({tag, "_note"}, int'(n1), v.note);
            chk({tag, "_step"}, int'(s1), v.step);
            chk({tag, "_busy"}, int'(b1), v.busy);
            chk({tag, "_done"}, int'(d1), v.done);
        end
    endtask

    int dcount;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;

        // Reference song, no gaps; extra starts at 10 and 20 must be ignored.
        add(0, 0, 1, 0, 0, 0, 0);     add(1, 0, 0, 13, 0, 1, 0);
        add(8, 0, 0, 13, 0, 1, 0);    add(9, 0, 0, 15, 1, 1, 0);
        add(10, 0, 1, 15, 1, 1, 0);   add(16, 0, 0, 15, 1, 1, 0);
        add(17, 0, 0, 17, 2, 1, 0);   add(20, 0, 1, 17, 2, 1, 0);
        add(25, 0, 0, 18, 3, 1, 0);   add(40, 0, 0, 18, 3, 1, 0);
        add(41, 0, 0, 0, 4, 1, 0);    add(44, 0, 0, 0, 4, 1, 0);
        add(45, 0, 0, 20, 5, 1, 0);   add(53, 0, 0, 22, 6, 1, 0);
        add(61, 0, 0, 25, 7, 1, 0);   add(76, 0, 0, 25, 7, 1, 0);
        add(77, 0, 0, 0, 0, 0, 1);    add(78, 0, 0, 0, 0, 0, 0);
        // Same run with one-tick gaps.
        add(1, 1, 0, 13, 0, 1, 0);    add(8, 1, 0, 13, 0, 1, 0);
        add(9, 1, 0, 0, 0, 1, 0);     add(12, 1, 0, 0, 0, 1, 0);
        add(13, 1, 0, 15, 1, 1, 0);   add(57, 1, 0, 0, 4, 1, 0);
        add(89, 1, 0, 25, 7, 1, 0);   add(104, 1, 0, 25, 7, 1, 0);
        add(105, 1, 0, 0, 7, 1, 0);   add(108, 1, 0, 0, 7, 1, 0);
        add(109, 1, 0, 0, 0, 0, 1);   add(110, 1, 0, 0, 0, 0, 0);

        // Reset state, asserted.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_note", int'(n0), 0);
        chk("rst_busy", int'(b0), 0);
        chk("rst_step", int'(s0), 0);
        chk("rst_done", int'(d1), 0);
        #3 rst_n = 1'b1;
        // Stays idle after release without a start.
        repeat (3) cyc();
        chk("idle_after_rst", int'(b0), 0);

        for (int c = 0; c <= 112; c++) begin
            start = 1'b0;
            foreach (tbl[i]) if (tbl[i].cyc == c && tbl[i].st) start = 1'b1;
            foreach (tbl[i]) if (tbl[i].cyc == c) check_vec(tbl[i]);
            cyc();
        end
        start = 1'b0;

        // Stop at cycle 30, no done afterwards, then replay from entry 0.
        start = 1'b1; cyc(); start = 1'b0;
        for (int c = 1; c < 30; c++) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("stop_note", int'(n0), 0);
        chk("stop_busy", int'(b0), 0);
        chk("stop_step", int'(s0), 0);
        chk("stop_busy_gap", int'(b1), 0);
        dcount = 0;
        for (int c = 0; c < 60; c++) begin cyc(); dcount += int'(d0) + int'(d1); end
        chk("no_done_after_stop", dcount, 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("replay_note", int'(n0), 13);
        chk("replay_step", int'(s0), 0);
        chk("replay_busy", int'(b0), 1);
        stop = 1'b1; cyc(); stop = 1'b0;

        // Start and stop together from idle.
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk("startstop_busy", int'(b0), 0);
        chk("startstop_note", int'(n0), 0);
        cyc();
        chk("startstop_busy2", int'(b1), 0);

        // Stop on the final-entry completion cycle suppresses done.
        start = 1'b1; cyc(); start = 1'b0;
        for (int c = 1; c < 76; c++) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("stop_at_end_done", int'(d0), 0);
        chk("stop_at_end_busy", int'(b0), 0);

        // Looping playback.
        loop = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        dcount = 0;
        for (int c = 1; c < 77; c++) begin cyc(); dcount += int'(d0); end
        chk("loop_note", int'(n0), 13);
        chk("loop_step", int'(s0), 0);
        chk("loop_busy", int'(b0), 1);
        chk("loop_no_done", dcount + int'(d0), 0);
        for (int c = 77; c < 153; c++) cyc();
        chk("loop2_note", int'(n0), 13);
        loop = 1'b0;
        stop = 1'b1; cyc(); stop = 1'b0;

        // Asynchronous reset mid-song.
        start = 1'b1; cyc(); start = 1'b0;
        for (int c = 1; c < 50; c++) cyc();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_note", int'(n0), 0);
        chk("arst_busy", int'(b0), 0);
        chk("arst_step", int'(s0), 0);
        chk("arst_done", int'(d0), 0);
        chk("arst_note_gap", int'(n1), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 100; c++) begin cyc(); dcount += int'(d0) + int'(d1) + int'(b0); end
        chk("arst_quiet_after", dcount, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) loop = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1 check_models();
                #1 rst_n = 1'b1;
            end
            cyc();
        end
        start = 1'b0; stop = 1'b0; loop = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
